// File: rtl/motor_pkg.sv
// Shared types and constants for the motor drive chain: bridge state,
// per-leg drive mode, default PWM timing and the duty magnitude helper.
package motor_pkg;

  localparam int DUTY_W       = 24;
  localparam int CNT_W        = 16;
  localparam int PERIOD_DEF   = 800;
  localparam int DEADTIME_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FWD    = 2'd1,
    ST_REV    = 2'd2,
    ST_SWITCH = 2'd3
  } bridge_state_t;

  typedef enum logic [1:0] {
    LEG_PWM    = 2'd0,
    LEG_LOW_ON = 2'd1,
    LEG_OFF    = 2'd2,
    LEG_BRAKE  = 2'd3
  } leg_mode_t;

  // |duty| computed one bit wider than the command so that -2^23 cannot
  // overflow, then clamped to the largest usable magnitude.
  function automatic logic [CNT_W-1:0] sat_mag(input logic signed [DUTY_W-1:0] duty,
                                               input logic [CNT_W-1:0]         max_mag);
    logic signed [DUTY_W:0] duty_ext;
    logic [DUTY_W:0]        duty_abs;
    duty_ext = {duty[DUTY_W-1], duty};
    duty_abs = duty_ext[DUTY_W] ? $unsigned(-duty_ext) : $unsigned(duty_ext);
    if (duty_abs > {{(DUTY_W+1-CNT_W){1'b0}}, max_mag})
      sat_mag = max_mag;
    else
      sat_mag = duty_abs[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/hbridge_leg.sv
// One half-bridge leg: decodes the shared PWM counter against the latched
// magnitude and produces registered high/low gate drives with deadtime gaps
// on both edges of the high-side pulse.
module hbridge_leg
  import motor_pkg::*;
#(
  parameter int PERIOD   = PERIOD_DEF,
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [CNT_W-1:0] counter,
  input  logic [CNT_W-1:0] mag,
  input  leg_mode_t        mode,
  output logic             hi,
  output logic             lo
);

  // One extra bit so mag + DEADTIME never wraps near the top of the range.
  localparam logic [CNT_W:0] DT_W   = (CNT_W+1)'(DEADTIME);
  localparam logic [CNT_W:0] LO_END = (CNT_W+1)'(PERIOD - DEADTIME);

  logic [CNT_W:0] cnt_w;
  logic [CNT_W:0] mag_w;
  logic           hi_next;
  logic           lo_next;
  logic           hi_reg;
  logic           lo_reg;

  assign cnt_w = {1'b0, counter};
  assign mag_w = {1'b0, mag};

  // Gate decode for the counter value presented this cycle.
  always_comb begin
    hi_next = 1'b0;
    lo_next = 1'b0;
    case (mode)
      LEG_PWM: begin
        hi_next = (cnt_w >= DT_W) && (cnt_w < mag_w);
        lo_next = (cnt_w >= mag_w + DT_W) && (cnt_w < LO_END);
      end
      LEG_LOW_ON, LEG_BRAKE: lo_next = 1'b1;
      default: ;
    endcase
  end

  // Register the gates so they line up one cycle behind the counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      hi_reg <= 1'b0;
      lo_reg <= 1'b0;
    end else begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: rtl/pwm_hbridge.sv
// Sign-magnitude PWM driver for a full H-bridge. Latches the signed duty
// command at period boundaries, sequences direction changes through a full
// all-off SWITCH period and drives two hbridge_leg instances.
// Optional low-side brake in IDLE: define PWM_HBRIDGE_BRAKE_EN.
module pwm_hbridge
  import motor_pkg::*;
#(
  parameter int PERIOD   = PERIOD_DEF,
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic signed [DUTY_W-1:0] duty,
  input  logic                     enable,
  output logic                     hi_a,
  output logic                     lo_a,
  output logic                     hi_b,
  output logic                     lo_b,
  output logic                     period_start,
  output logic [1:0]               dir
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MAX_MAG  = CNT_W'(PERIOD - DEADTIME);

  bridge_state_t    state_reg;
  bridge_state_t    state_next;
  bridge_state_t    target;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] mag_reg;
  logic [CNT_W-1:0] mag_next;
  logic [CNT_W-1:0] duty_mag;
  logic             hold_off_reg;
  logic             hold_off_next;
  logic             period_start_reg;
  logic             boundary;
  leg_mode_t        leg_mode [2];
  logic [1:0]       leg_hi;
  logic [1:0]       leg_lo;

  assign boundary = (cnt_reg == LAST_CNT);
  assign duty_mag = sat_mag(duty, MAX_MAG);

  // Direction requested by the command currently on the duty input.
  always_comb begin
    if (duty == '0)
      target = ST_IDLE;
    else if (duty[DUTY_W-1])
      target = ST_REV;
    else
      target = ST_FWD;
  end

  // Counter, magnitude latch and the post-disable hold-off flag. The flag
  // keeps the bridge dark until the next boundary after enable or reset, so
  // the first drive pattern always starts from a clean period edge.
  always_comb begin
    cnt_next      = boundary ? '0 : cnt_reg + 1'b1;
    mag_next      = boundary ? duty_mag : mag_reg;
    hold_off_next = hold_off_reg;
    if (!enable)
      hold_off_next = 1'b1;
    else if (boundary)
      hold_off_next = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_reg          <= '0;
      mag_reg          <= '0;
      hold_off_reg     <= 1'b1;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= cnt_next;
      mag_reg          <= mag_next;
      hold_off_reg     <= hold_off_next;
      period_start_reg <= (cnt_reg == '0);
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state: any change away from an active direction passes through one
  // whole SWITCH period before the newly latched target takes over.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_IDLE;
    end else if (boundary) begin
      case (state_reg)
        ST_IDLE, ST_SWITCH: state_next = target;
        default:            state_next = (target == state_reg) ? state_reg : ST_SWITCH;
      endcase
    end
  end

  // Output decode: per-leg drive mode from state (index 0 = leg A, 1 = leg B).
  always_comb begin
    leg_mode[0] = LEG_OFF;
    leg_mode[1] = LEG_OFF;
    if (enable && !hold_off_reg) begin
      case (state_reg)
        ST_FWD: begin
          leg_mode[0] = LEG_PWM;
          leg_mode[1] = LEG_LOW_ON;
        end
        ST_REV: begin
          leg_mode[0] = LEG_LOW_ON;
          leg_mode[1] = LEG_PWM;
        end
        ST_IDLE: begin
`ifdef PWM_HBRIDGE_BRAKE_EN
          leg_mode[0] = LEG_BRAKE;
          leg_mode[1] = LEG_BRAKE;
`else
          leg_mode[0] = LEG_OFF;
          leg_mode[1] = LEG_OFF;
`endif
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_leg
      hbridge_leg #(
        .PERIOD   (PERIOD),
        .DEADTIME (DEADTIME)
      ) u_leg (
        .CLK     (CLK),
        .reset   (reset),
        .counter (cnt_reg),
        .mag     (mag_reg),
        .mode    (leg_mode[gi]),
        .hi      (leg_hi[gi]),
        .lo      (leg_lo[gi])
      );
    end
  endgenerate

  assign hi_a         = leg_hi[0];
  assign lo_a         = leg_lo[0];
  assign hi_b         = leg_hi[1];
  assign lo_b         = leg_lo[1];
  assign period_start = period_start_reg;
  assign dir          = state_reg;

endmodule

// File: doc/pwm_hbridge.md
Name: pwm_hbridge

Overview:
Downstream stage of the motor PID controller. Consumes the signed 24-bit duty command and drives the four gate signals of a full H-bridge using sign-magnitude PWM.
- Enforces shoot-through deadtime within each leg.
- Inserts an all-off period on every direction change.
- Latches the command only at PWM period boundaries.

Parameters:
PERIOD, 800, PWM period in CLK cycles (20 kHz at 16 MHz); legal range 4*DEADTIME+2 .. 65535.
DEADTIME, 8, CLK cycles during which both switches of a leg are off at each transition.

Ports:
CLK  input  1  system clock; sole clock domain.
reset  input  1  synchronous, active-high reset.
duty  input  24  signed duty command in counts of PERIOD; sign selects direction.
enable  input  1  bridge enable; low forces all gates off.
hi_a  output  1  leg A high-side gate, active-high.
lo_a  output  1  leg A low-side gate, active-high.
hi_b  output  1  leg B high-side gate, active-high.
lo_b  output  1  leg B low-side gate, active-high.
period_start  output  1  one-cycle pulse when the counter equals 0.
dir  output  2  current state: 0=IDLE, 1=FWD, 2=REV, 3=SWITCH.

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous and active-high, sampled on the CLK rising edge.
- Reset values:
  - all gate outputs 0 and period_start 0;
  - dir=IDLE;
  - counter 0; latched magnitude 0; latched sign 0.
- Counter: free-running 0..PERIOD-1, wraps to 0.
- Command latch:
  - Duty is sampled when counter==PERIOD-1 and takes effect from counter==0.
  - Changes to duty mid-period are ignored until the next boundary.
- Magnitude: mag = |duty|, saturated to MAXMAG = PERIOD-DEADTIME.
  - duty = -2^23 saturates to MAXMAG; no overflow is permitted.
  - Compute in 25 bits before clamping.
- Target state at the latch:
  - duty>0 gives FWD; duty<0 gives REV; duty==0 gives IDLE.
- State transitions, evaluated at each period boundary:
  - Current IDLE or SWITCH: go to the target directly.
  - Current FWD/REV with the same target: stay.
  - Current FWD/REV with a different target (opposite direction or IDLE): go to SWITCH for exactly one full period, then to the target latched at the end of that SWITCH period.
- Gate equations, with c = counter:
  - FWD:
    - hi_a = (c>=DEADTIME && c<mag);
    - lo_a = (c>=mag+DEADTIME && c<PERIOD-DEADTIME);
    - lo_b = 1; hi_b = 0.
  - REV: same equations with legs A and B swapped.
  - IDLE and SWITCH: all gates 0 (coast).
  - Effective high-side on-time = max(0, mag-DEADTIME).
  - mag<=DEADTIME gives hi never on; mag>=PERIOD-2*DEADTIME gives lo never on.
- Latency: gate outputs are registered one cycle after the counter value they decode.
  - Invariant, checked every cycle: never hi_x && lo_x; a leg never goes from hi to lo (or lo to hi) in fewer than DEADTIME cycles of all-off.
- enable low:
  - gates 0 on the next cycle; state forced to IDLE; counter keeps running.
  - On re-assertion, the command is applied at the next boundary.
- reset mid-period: all outputs 0 next cycle; the counter restarts at 0.
- period_start is registered and aligned with the gate outputs for c==0.

Optional Feature:
Macro: PWM_HBRIDGE_BRAKE_EN.
- Defined: in IDLE with enable high, lo_a=lo_b=1 (low-side brake). SWITCH stays all-off, so deadtime is preserved on every entry to and exit from brake.
- Undefined: IDLE coasts with all gates 0.

Decomposition:
- Shared package motor_pkg holds:
  - bridge state enum (IDLE/FWD/REV/SWITCH, 2 bits);
  - DUTY_W=24;
  - the default PERIOD and DEADTIME constants.
- One sub-module, hbridge_leg. Inputs: counter, mag, and leg mode (PWM / LOW_ON / OFF / BRAKE). Outputs: hi and lo for one leg, registered. It is instantiated twice.

Test Plan:
1. PERIOD=800, DEADTIME=8, duty=+400 -> hi_a high for c=8..399 (392 cycles); lo_a high for c=408..791; lo_b=1; hi_b=0; no overlap.
2. duty=+100000 or duty=-8388608 -> mag=792; high side on for c=8..791; low side of the PWM leg never on; no X or overflow.
3. duty changes +400 to -400 at c=300 -> current FWD period completes unchanged; one full period all-off (dir=3); then REV with hi_b on for c=8..399 and lo_a=1.
4. duty=0 from FWD -> one SWITCH period, then IDLE with all gates 0. With PWM_HBRIDGE_BRAKE_EN: lo_a=lo_b=1 after SWITCH.
5. enable dropped at c=200 during FWD -> all gates 0 one cycle later. Re-asserted at c=500 -> gates remain 0 until the next c=0, then FWD resumes.
6. reset asserted at c=350 during REV -> next cycle all outputs 0, dir=0, counter=0. Deadtime assertion holds throughout a random duty sweep of 10^5 cycles.
